// File: rtl/rot_seq_pkg.sv
// Shared definitions for the rotate-register sequencer: state encoding and default widths.
package rot_seq_pkg;

    localparam int unsigned DEF_DW = 4;
    localparam int unsigned DEF_CW = 8;
    localparam int unsigned DEF_PW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } rot_seq_state_t;

endpackage

// File: rtl/rot_seq_prescaler.sv
// Loadable PW-bit down-counter with zero flag; spaces rotate-enable pulses.
module rot_seq_prescaler #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          sync_rst_n,
    input  logic          i_load,
    input  logic [PW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero_c
);

    logic [PW-1:0] r_cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - PW'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/rotate_seq_ctrl.sv
// Sequencer driving load/en/data of a right-rotate register stage.
// Optional abort input is built when ROT_SEQ_ABORT_EN is defined.
module rotate_seq_ctrl
    import rot_seq_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned CW = DEF_CW,
    parameter int unsigned PW = DEF_PW
) (
    input  logic          clk,
    input  logic          sync_rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [CW-1:0] in_count,
    input  logic [PW-1:0] in_period,
`ifdef ROT_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic          load,
    output logic          en,
    output logic [DW-1:0] data,
    output logic          busy,
    output logic          done
);

    rot_seq_state_t r_state;
    rot_seq_state_t w_next_state;

    logic [DW-1:0] r_data;
    logic [CW-1:0] r_remaining;
    logic [PW-1:0] r_period;

    logic w_accept;
    logic w_pre_load;
    logic w_pre_dec;
    logic w_pre_zero;
    logic w_rem_dec;

    rot_seq_prescaler #(
        .PW(PW)
    ) u_prescaler (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .i_load     (w_pre_load),
        .i_load_val (r_period),
        .i_dec      (w_pre_dec),
        .o_zero_c   (w_pre_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and counter control
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_pre_load   = 1'b0;
        w_pre_dec    = 1'b0;
        w_rem_dec    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_pre_load = 1'b1;
                if (r_remaining == '0) begin
                    w_next_state = FIN;
                end else begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_pre_zero) begin
                    w_pre_load = 1'b1;
                    w_rem_dec  = 1'b1;
                    if (r_remaining == CW'(1)) begin
                        w_next_state = FIN;
                    end
                end else begin
                    w_pre_dec = 1'b1;
                end
            end
            FIN: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
`ifdef ROT_SEQ_ABORT_EN
        if (abort && ((r_state == LOAD) || (r_state == RUN))) begin
            w_next_state = IDLE;
        end
`endif
    end

    // Job capture: seed and period held until the next handshake
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            r_data      <= '0;
            r_remaining <= '0;
            r_period    <= '0;
        end else if (w_accept) begin
            r_data      <= in_data;
            r_remaining <= in_count;
            r_period    <= in_period;
        end else if (w_rem_dec) begin
            r_remaining <= r_remaining - CW'(1);
        end
    end

    assign in_ready = sync_rst_n && (r_state == IDLE);
    assign load     = (r_state == LOAD);
    assign en       = (r_state == RUN) && w_pre_zero;
    assign done     = (r_state == FIN);
    assign busy     = (r_state != IDLE);
    assign data     = r_data;

endmodule
